// File: rtl/conv1d_k4_mac_if.sv
// Handshake/data bundle between the activation cache and the conv1d_k4_mac compute stage.
// Ports: start request, four packed tap vectors in_l0..in_l3 (D channels of W bits each),
//        busy status, packed result vector out and its one-cycle valid pulse out_v.
interface conv1d_k4_mac_if #(
    parameter int W = 16,
    parameter int D = 4
);
    logic           start;
    logic [D*W-1:0] in_l0;
    logic [D*W-1:0] in_l1;
    logic [D*W-1:0] in_l2;
    logic [D*W-1:0] in_l3;
    logic           busy;
    logic [D*W-1:0] out;
    logic           out_v;

    // Producer side: the activation cache / controller driving a conv step.
    modport master (
        output start, in_l0, in_l1, in_l2, in_l3,
        input  busy, out, out_v
    );

    // Compute stage side.
    modport slave (
        input  start, in_l0, in_l1, in_l2, in_l3,
        output busy, out, out_v
    );
endinterface

// File: rtl/conv1d_k4_mac.sv
// Kernel-4 dilated causal conv compute stage: one time-multiplexed signed MAC over 4 taps x D channels
// per output channel, with bias, truncating >>> FRAC, saturation and optional ReLU (macro RELU_EN).
// Ports: clk, rst (async active-high), bus (conv1d_k4_mac_if.slave). Latency D*(4*D+1)+1 cycles from
// accepted start to out_v; start is ignored while busy (no queueing), so the caller must wait for !busy.
// ROM images are elaboration-time parameters: WEIGHTS word o*4*D + k*D + i, BIAS word o, both W-bit
// signed Q(W-FRAC).FRAC. D must be a power of two >= 2 so the ROM index is a plain bit concatenation.
module conv1d_k4_mac #(
    parameter int                   W       = 16,
    parameter int                   D       = 4,
    parameter int                   FRAC    = 12,
    parameter logic [D*4*D*W-1:0]   WEIGHTS = '0,
    parameter logic [D*W-1:0]       BIAS    = '0
) (
    input  logic               clk,
    input  logic               rst,
    conv1d_k4_mac_if.slave     bus
);
    // Accumulator is wide enough that 4*D full-scale products plus the bias never overflow.
    localparam int AW = 2*W + 2 + $clog2(D) + 1;
    localparam int CW = $clog2(D);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MAC   = 2'd1;
    localparam logic [1:0] S_STORE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic signed [AW-1:0] MAXV = AW'((2**(W-1)) - 1);
    localparam logic signed [AW-1:0] MINV = ~MAXV;

    logic [1:0]            state;
    logic [D*W-1:0]        tap [4];
    logic [CW-1:0]         o_idx;
    logic [CW-1:0]         i_idx;
    logic [1:0]            k_idx;
    logic signed [AW-1:0]  acc;
    logic [D*W-1:0]        out_r;

    // Unpacked views of the ROM images and latched taps so every lookup index is exact-width.
    logic signed [W-1:0]   wrom    [D*4*D];
    logic signed [W-1:0]   brom    [D];
    logic signed [W-1:0]   tap_arr [4][D];

    for (genvar g = 0; g < D*4*D; g++) begin : g_wrom
        assign wrom[g] = WEIGHTS[g*W +: W];
    end
    for (genvar g = 0; g < D; g++) begin : g_brom
        assign brom[g] = BIAS[g*W +: W];
    end
    for (genvar kk = 0; kk < 4; kk++) begin : g_tk
        for (genvar ii = 0; ii < D; ii++) begin : g_ti
            assign tap_arr[kk][ii] = tap[kk][ii*W +: W];
        end
    end

    // Bias is sign-extended to the accumulator width and aligned to the product binary point.
    function automatic logic signed [AW-1:0] load_bias(input logic signed [W-1:0] b);
        return {{(AW-W){b[W-1]}}, b} << FRAC;
    endfunction

    logic signed [W-1:0]   tap_el;
    logic signed [W-1:0]   w_el;
    logic signed [2*W-1:0] prod;
    logic signed [AW-1:0]  shifted;
    logic signed [W-1:0]   sat_v;
    logic signed [W-1:0]   res;

    assign tap_el  = tap_arr[k_idx][i_idx];
    assign w_el    = wrom[{o_idx, k_idx, i_idx}];
    assign prod    = tap_el * w_el;
    // Arithmetic shift truncates toward -inf; no rounding term is added.
    assign shifted = acc >>> FRAC;

    always_comb begin
        sat_v = shifted[W-1:0];
        if (shifted > MAXV) begin
            sat_v = MAXV[W-1:0];
        end else if (shifted < MINV) begin
            sat_v = MINV[W-1:0];
        end
`ifdef RELU_EN
        res = sat_v[W-1] ? '0 : sat_v;
`else
        res = sat_v;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            for (int n = 0; n < 4; n++) begin
                tap[n] <= '0;
            end
            o_idx <= '0;
            i_idx <= '0;
            k_idx <= '0;
            acc   <= '0;
            out_r <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        // Taps are captured once here; the cache may move on while we compute.
                        tap[0] <= bus.in_l0;
                        tap[1] <= bus.in_l1;
                        tap[2] <= bus.in_l2;
                        tap[3] <= bus.in_l3;
                        o_idx  <= '0;
                        i_idx  <= '0;
                        k_idx  <= '0;
                        acc    <= load_bias(brom[0]);
                        state  <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc <= acc + {{(AW-2*W){prod[2*W-1]}}, prod};
                    if (i_idx == CW'(D-1)) begin
                        i_idx <= '0;
                        if (k_idx == 2'd3) begin
                            k_idx <= '0;
                            state <= S_STORE;
                        end else begin
                            k_idx <= k_idx + 2'd1;
                        end
                    end else begin
                        i_idx <= i_idx + CW'(1);
                    end
                end
                S_STORE: begin
                    out_r[o_idx*W +: W] <= res;
                    if (o_idx == CW'(D-1)) begin
                        state <= S_DONE;
                    end else begin
                        o_idx <= o_idx + CW'(1);
                        acc   <= load_bias(brom[o_idx + CW'(1)]);
                        state <= S_MAC;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = (state != S_IDLE);
    assign bus.out_v = (state == S_DONE);
    assign bus.out   = out_r;
endmodule

// File: tb/tb_conv1d_k4_mac.sv
module tb_conv1d_k4_mac;
    localparam int W  = 16;
    localparam int D  = 2;
    localparam int NV = D*W;
    localparam int NW = D*4*D*W;

    // Instance 0: zero weights, bias {ch0=1.0, ch1=-1.0}
    // Instance 1: identity on current tap (w[o][3][o]=1.0, words 6 and 15)
    // Instance 2: every weight 0x7FFF
    // Instance 3: single weight 0x0001 at o=0,k=0,i=0
    localparam logic [NW-1:0] WIMG [4] = '{
        256'h0,
        (256'h1000 << (6*16)) | (256'h1000 << (15*16)),
        {16{16'h7FFF}},
        256'h1
    };
    localparam logic [NV-1:0] BIMG [4] = '{32'hF000_1000, 32'h0, 32'h0, 32'h0};

`ifdef RELU_EN
    localparam logic [NV-1:0] EXP_BIAS = 32'h0000_1000;
    localparam logic [NV-1:0] EXP_ID   = 32'h0000_0800;
    localparam logic [NV-1:0] EXP_NEG  = 32'h0000_0000;
    localparam logic [NV-1:0] EXP_TR   = 32'h0000_0000;
`else
    localparam logic [NV-1:0] EXP_BIAS = 32'hF000_1000;
    localparam logic [NV-1:0] EXP_ID   = 32'hF800_0800;
    localparam logic [NV-1:0] EXP_NEG  = 32'h8000_8000;
    localparam logic [NV-1:0] EXP_TR   = 32'h0000_FFFF;
`endif
    localparam logic [NV-1:0] EXP_POS  = 32'h7FFF_7FFF;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [NV-1:0] in_l0, in_l1, in_l2, in_l3;
    logic [NV-1:0] out_w  [4];
    logic          vld_w  [4];
    logic          busy_w [4];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : u
        conv1d_k4_mac_if #(.W(W), .D(D)) bus ();
        assign bus.start = start;
        assign bus.in_l0 = in_l0;
        assign bus.in_l1 = in_l1;
        assign bus.in_l2 = in_l2;
        assign bus.in_l3 = in_l3;
        assign out_w[g]  = bus.out;
        assign vld_w[g]  = bus.out_v;
        assign busy_w[g] = bus.busy;
        conv1d_k4_mac #(.W(W), .D(D), .FRAC(12), .WEIGHTS(WIMG[g]), .BIAS(BIMG[g])) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int g);
        int t = 0;
        while (busy_w[g] !== 1'b0 && t < 200) begin
            step();
            t++;
        end
        if (busy_w[g] !== 1'b0) begin
            $display("FAIL wait_idle dut%0d: busy=%b after %0d cycles, required 0", g, busy_w[g], t);
            n_bad++;
        end
        n_cmp++;
    endtask

    // Pulse start for one cycle (cycle 0) and return the cycle index at which out_v is seen.
    task automatic run_step(input int g, output int lat);
        start = 1'b1;
        step();
        start = 1'b0;
        lat = 1;
        while (vld_w[g] !== 1'b1 && lat < 200) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        in_l0 = '0; in_l1 = '0; in_l2 = '0; in_l3 = '0;
        step();
        step();
        for (int g = 0; g < 4; g++) begin
            if (out_w[g] !== '0) begin
                $display("FAIL reset_out dut%0d: got %h, required 0", g, out_w[g]); n_bad++;
            end
            n_cmp++;
            if (vld_w[g] !== 1'b0) begin
                $display("FAIL reset_out_v dut%0d: got %b, required 0", g, vld_w[g]); n_bad++;
            end
            n_cmp++;
            if (busy_w[g] !== 1'b0) begin
                $display("FAIL reset_busy dut%0d: got %b, required 0", g, busy_w[g]); n_bad++;
            end
            n_cmp++;
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_bias();
        int lat;
        wait_idle(0);
        in_l0 = 32'h1111_2222; in_l1 = 32'h3333_4444; in_l2 = 32'h5555_6666; in_l3 = 32'h7777_0888;
        run_step(0, lat);
        if (lat !== 19) begin
            $display("FAIL bias_latency: got %0d, required 19", lat); n_bad++;
        end
        n_cmp++;
        if (out_w[0] !== EXP_BIAS) begin
            $display("FAIL bias_out: got %h, required %h", out_w[0], EXP_BIAS); n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_identity();
        int c;
        wait_idle(1);
        in_l0 = 32'h1234_5678; in_l1 = 32'h0F0F_7070; in_l2 = 32'hAAAA_5555; in_l3 = 32'hF800_0800;
        start = 1'b1;
        step();
        start = 1'b0;
        c = 1;
        while (vld_w[1] !== 1'b1 && c < 200) begin
            step();
            c++;
            // Mid-step change of the current tap must not leak into the result.
            if (c == 3) in_l3 = 32'h0100_0100;
        end
        if (c !== 19) begin
            $display("FAIL identity_latency: got %0d, required 19", c); n_bad++;
        end
        n_cmp++;
        if (out_w[1] !== EXP_ID) begin
            $display("FAIL identity_out: got %h, required %h", out_w[1], EXP_ID); n_bad++;
        end
        n_cmp++;
        in_l3 = 32'hF800_0800;
    endtask

    task automatic test_saturation();
        int lat;
        wait_idle(2);
        in_l0 = 32'h7FFF_7FFF; in_l1 = 32'h7FFF_7FFF; in_l2 = 32'h7FFF_7FFF; in_l3 = 32'h7FFF_7FFF;
        run_step(2, lat);
        if (out_w[2] !== EXP_POS) begin
            $display("FAIL sat_pos: got %h, required %h (lat %0d)", out_w[2], EXP_POS, lat); n_bad++;
        end
        n_cmp++;
        wait_idle(2);
        in_l0 = 32'h8000_8000; in_l1 = 32'h8000_8000; in_l2 = 32'h8000_8000; in_l3 = 32'h8000_8000;
        run_step(2, lat);
        if (out_w[2] !== EXP_NEG) begin
            $display("FAIL sat_neg: got %h, required %h (lat %0d)", out_w[2], EXP_NEG, lat); n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_truncation();
        int lat;
        wait_idle(3);
        in_l0 = 32'h0000_FFFF; in_l1 = '0; in_l2 = '0; in_l3 = '0;
        run_step(3, lat);
        if (lat !== 19) begin
            $display("FAIL trunc_latency: got %0d, required 19", lat); n_bad++;
        end
        n_cmp++;
        if (out_w[3] !== EXP_TR) begin
            $display("FAIL trunc_out: got %h, required %h", out_w[3], EXP_TR); n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_handshake();
        int c, n_vld, first_vld, busy_cnt, busy_first, busy_last;
        wait_idle(0);
        n_vld = 0; first_vld = -1; busy_cnt = 0; busy_first = -1; busy_last = -1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (c = 1; c <= 45; c++) begin
            if (vld_w[0] === 1'b1) begin
                n_vld++;
                if (first_vld < 0) first_vld = c;
            end
            if (busy_w[0] === 1'b1) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = c;
                busy_last = c;
            end
            // Extra start pulses while busy (cycle 5) and in the DONE cycle (19) are dropped.
            start = (c == 5 || c == 19);
            step();
        end
        start = 1'b0;
        if (n_vld !== 1) begin
            $display("FAIL hs_vld_count: got %0d, required 1", n_vld); n_bad++;
        end
        n_cmp++;
        if (first_vld !== 19) begin
            $display("FAIL hs_vld_cycle: got %0d, required 19", first_vld); n_bad++;
        end
        n_cmp++;
        if (busy_first !== 1) begin
            $display("FAIL hs_busy_first: got %0d, required 1", busy_first); n_bad++;
        end
        n_cmp++;
        if (busy_last !== 19) begin
            $display("FAIL hs_busy_last: got %0d, required 19", busy_last); n_bad++;
        end
        n_cmp++;
        if (busy_cnt !== 19) begin
            $display("FAIL hs_busy_count: got %0d, required 19", busy_cnt); n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_back_to_back();
        int c, v1, v2;
        wait_idle(0);
        v1 = -1; v2 = -1;
        start = 1'b1;
        step();
        for (c = 1; c <= 60; c++) begin
            if (vld_w[0] === 1'b1) begin
                if (v1 < 0) v1 = c;
                else if (v2 < 0) v2 = c;
            end
            step();
        end
        start = 1'b0;
        if (v1 !== 19) begin
            $display("FAIL b2b_first: got %0d, required 19", v1); n_bad++;
        end
        n_cmp++;
        if (v2 !== 39) begin
            $display("FAIL b2b_second: got %0d, required 39", v2); n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_rst_abort();
        int c, lat;
        wait_idle(1);
        in_l0 = '0; in_l1 = '0; in_l2 = '0; in_l3 = 32'hF800_0800;
        start = 1'b1;
        step();
        start = 1'b0;
        for (c = 1; c < 7; c++) step();
        rst = 1'b1;
        #1;
        if (out_w[1] !== '0) begin
            $display("FAIL rst_abort_out: got %h, required 0", out_w[1]); n_bad++;
        end
        n_cmp++;
        if (vld_w[1] !== 1'b0) begin
            $display("FAIL rst_abort_out_v: got %b, required 0", vld_w[1]); n_bad++;
        end
        n_cmp++;
        if (busy_w[1] !== 1'b0) begin
            $display("FAIL rst_abort_busy: got %b, required 0", busy_w[1]); n_bad++;
        end
        n_cmp++;
        step();
        rst = 1'b0;
        step();
        run_step(1, lat);
        if (lat !== 19) begin
            $display("FAIL rst_rerun_latency: got %0d, required 19", lat); n_bad++;
        end
        n_cmp++;
        if (out_w[1] !== EXP_ID) begin
            $display("FAIL rst_rerun_out: got %h, required %h", out_w[1], EXP_ID); n_bad++;
        end
        n_cmp++;
    endtask

    initial begin
        test_reset();
        test_bias();
        test_identity();
        test_saturation();
        test_truncation();
        test_handshake();
        test_back_to_back();
        test_rst_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
